fetch_stage: RTL and testbench

Instruction fetch stage: owns the program counter, issues one instruction-memory request at a time over a request/grant/response handshake, and buffers the returned word. It presents `instr_f` / `pc_plus4_f` to the IF/ID decode register, honours the hazard unit's stall, and applies branch/jump redirects from execute, squashing any in-flight fetch.

---
 rtl/fetch_stage.sv | 90 +++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: PC owner issuing one imem request at a time, buffering the word for decode.
// Optional FETCH_PERF_CNT_EN adds perf_fetched / perf_squashed counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_f,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_f,
  output logic [31:0] pc_plus4_f,
  output logic        fetch_valid,
  output logic [31:0] pc_f
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_squashed
`endif
);
  typedef enum logic {REQ, WAIT} state_t;
  state_t state, state_n;
  logic [31:0] pc, req_pc, instr_buf, pc4_buf;
  logic valid_buf, squash, consume, fire, rsp, fill, drop;
  assign consume = valid_buf & ~stall_f;
  assign imem_req = (state == REQ) & (~valid_buf | consume);
  assign fire = imem_req & imem_gnt;
  assign rsp = (state == WAIT) & imem_rvalid;
  assign fill = rsp & ~squash & ~redirect;
  assign drop = rsp & (squash | redirect);
  assign imem_addr = pc;
  assign instr_f = instr_buf;
  assign pc_plus4_f = pc4_buf;
  assign fetch_valid = valid_buf;
  assign pc_f = pc;
  always_comb begin
    state_n = state;
    state_n = (state == REQ) ? (fire ? WAIT : REQ) : (imem_rvalid ? REQ : WAIT);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= REQ;
      pc        <= RESET_PC;
      req_pc    <= '0;
      instr_buf <= '0;
      pc4_buf   <= '0;
      valid_buf <= 1'b0;
      squash    <= 1'b0;
    end else begin
      state <= state_n;
      if (fire) req_pc <= pc;
      if (redirect) begin
        pc        <= redirect_pc & 32'hFFFF_FFFC;
        instr_buf <= '0;
        pc4_buf   <= '0;
        valid_buf <= 1'b0;
        // a request still outstanding after this edge must have its response discarded
        squash    <= (state_n == WAIT);
      end else begin
        if (fire) pc <= pc + 32'd4;
        if (rsp) squash <= 1'b0;
        if (fill) begin
          instr_buf <= imem_rdata;
          pc4_buf   <= req_pc + 32'd4;
          valid_buf <= 1'b1;
        end else if (consume) begin
          instr_buf <= '0;
          pc4_buf   <= '0;
          valid_buf <= 1'b0;
        end
      end
    end
  end
`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      if (fill) perf_fetched <= perf_fetched + 32'd1;
      if (drop | (redirect & valid_buf)) perf_squashed <= perf_squashed + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed and randomized checks of fetch_stage against a stream-level model.
module tb_fetch_stage;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 0, reset = 0, stall_f = 0, redirect = 0, imem_gnt = 0, imem_rvalid = 0;
  logic [31:0] redirect_pc = 0, imem_rdata = 0;
  logic imem_req, fetch_valid, imem_req2, fetch_valid2;
  logic [31:0] imem_addr, instr_f, pc_plus4_f, pc_f;
  logic [31:0] imem_addr2, instr_f2, pc_plus4_f2, pc_f2;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed, perf_fetched2, perf_squashed2;
`endif
  int checks = 0, errors = 0, consumed = 0, dly = 0, lat = 0;
  bit pend = 0, rnd = 0, hold = 0;
  logic [31:0] pend_addr = 0, exp_pc = 0, hold_instr = 0;
  logic s_req, s_valid, s_req2;
  logic [31:0] s_addr, s_instr, s_pc4, s_pcf, s_addr2;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .reset(reset), .stall_f(stall_f), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_f(instr_f), .pc_plus4_f(pc_plus4_f), .fetch_valid(fetch_valid),
    .pc_f(pc_f)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched), .perf_squashed(perf_squashed)
`endif
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
    .clk(clk), .reset(reset), .stall_f(stall_f), .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .instr_f(instr_f2), .pc_plus4_f(pc_plus4_f2), .fetch_valid(fetch_valid2),
    .pc_f(pc_f2)
`ifdef FETCH_PERF_CNT_EN
    , .perf_fetched(perf_fetched2), .perf_squashed(perf_squashed2)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, sample, then advance memory and stream model.
  task automatic cyc(input bit st = 0, input bit rd = 0, input logic [31:0] rpc = 0);
    stall_f = st;
    redirect = rd;
    redirect_pc = rpc;
    imem_rvalid = pend && dly == 0;
    imem_rdata = imem_rvalid ? (pend_addr ^ K) : $urandom;
    #1;
    imem_gnt = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
    s_req = imem_req; s_addr = imem_addr; s_valid = fetch_valid; s_instr = instr_f;
    s_pc4 = pc_plus4_f; s_pcf = pc_f; s_req2 = imem_req2; s_addr2 = imem_addr2;
    if (pend) chk("one_outstanding", imem_req, 0);
    if (hold) begin
      chk("stall_hold_valid", fetch_valid, 1);
      chk("stall_hold_instr", instr_f, hold_instr);
    end
    if (reset && fetch_valid && !st && !rd) begin
      chk("stream_instr", instr_f, exp_pc ^ K);
      chk("stream_pc4", pc_plus4_f, exp_pc + 32'd4);
    end
    hold = reset && !rd && fetch_valid && st;
    hold_instr = instr_f;
    @(posedge clk);
    if (!reset) begin
      pend = 0;
      exp_pc = 32'h0;
      hold = 0;
    end else begin
      if (s_valid && !st && !rd) begin
        exp_pc += 32'd4;
        consumed++;
      end
      if (rd) exp_pc = rpc & 32'hFFFF_FFFC;
      if (imem_rvalid) pend = 0;
      if (s_req && imem_gnt) begin
        pend = 1;
        pend_addr = s_addr;
        dly = rnd ? $urandom_range(0, 3) : lat;
      end else if (pend && dly > 0) dly--;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 0;
    cyc();
    cyc();
    reset = 1;
  endtask

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_instr", instr_f, 0);
    chk("rst_pc4", pc_plus4_f, 0);
    chk("rst_valid", fetch_valid, 0);
    chk("rst_pc_f", pc_f, 0);
    chk("rst_req", imem_req, 1);
    chk("rst_pc_f_hi", pc_f2, 32'hFFFF_FFFC);
    // zero-wait stream: requests 0,4,8 in cycles 0,2,4
    cyc(); chk("t1_req0", s_req, 1); chk("t1_addr0", s_addr, 0); chk("t1_hi_addr0", s_addr2, 32'hFFFF_FFFC);
    cyc(); chk("t1_req1", s_req, 0);
    cyc(); chk("t1_req2", s_req, 1); chk("t1_addr2", s_addr, 4); chk("t1_valid2", s_valid, 1);
    chk("t1_instr2", s_instr, 32'hA5A5_0000); chk("t1_pc4_2", s_pc4, 4);
    chk("t1_hi_req2", s_req2, 1); chk("t1_hi_wrap", s_addr2, 0);
    cyc(); cyc(); chk("t1_req4", s_req, 1); chk("t1_addr4", s_addr, 8);
    // stall holds buffered 0x4 word
    do_reset();
    repeat (4) cyc();
    for (int i = 0; i < 3; i++) begin
      cyc(1);
      chk("t2_req_stall", s_req, 0); chk("t2_valid", s_valid, 1);
      chk("t2_instr", s_instr, 32'hA5A5_0004); chk("t2_pc4", s_pc4, 8);
    end
    cyc(); chk("t2_req_release", s_req, 1); chk("t2_addr_release", s_addr, 8);
    // redirect during WAIT, stale response two cycles later
    do_reset();
    lat = 2;
    cyc();
    cyc(0, 1, 32'h103);
    cyc(); chk("t3_req_a", s_req, 0); chk("t3_valid_a", s_valid, 0); chk("t3_pc_f", s_pcf, 32'h100);
    cyc(); chk("t3_req_b", s_req, 0);
    cyc(); chk("t3_valid_c", s_valid, 0); chk("t3_req_c", s_req, 1); chk("t3_addr_c", s_addr, 32'h100);
    repeat (3) cyc();
    cyc(); chk("t3_valid_d", s_valid, 1); chk("t3_instr_d", s_instr, 32'h100 ^ K); chk("t3_pc4_d", s_pc4, 32'h104);
    lat = 0;
    // redirect coinciding with the response
    do_reset();
    cyc();
    cyc(0, 1, 32'h200);
    cyc(); chk("t4_req", s_req, 1); chk("t4_addr", s_addr, 32'h200); chk("t4_valid", s_valid, 0);
    cyc();
    cyc(); chk("t4_valid_fill", s_valid, 1); chk("t4_instr_fill", s_instr, 32'h200 ^ K);
`ifdef FETCH_PERF_CNT_EN
    do_reset();
    repeat (10) cyc();
    cyc(0, 1, 32'h40);
    chk("perf_fetched", perf_fetched, 5);
    chk("perf_squashed", perf_squashed, 1);
    reset = 0;
    cyc();
    chk("perf_fetched_rst", perf_fetched, 0);
    chk("perf_squashed_rst", perf_squashed, 0);
    reset = 1;
`endif
    // randomized traffic: random grants, latency, stalls, redirects and occasional reset
    rnd = 1;
    do_reset();
    consumed = 0;
    repeat (4000) begin
      reset = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 2) == 0, $urandom_range(0, 19) == 0, $urandom);
    end
    reset = 1;
    chk("random_progress", consumed >= 100, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
